rom_dl_ctrl: RTL and testbench

ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

---
 rtl/rom_dl_pkg.sv | 23 ++
 rtl/dl_fifo.sv | 66 ++++++
 rtl/rom_dl_ctrl.sv | 156 +++++++++++++++
 tb/tb_rom_dl_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// Shared types and defaults for the ROM download controller.
package rom_dl_pkg;

  localparam logic [24:0] BG_BASE_DEF = 25'h000E000;
  localparam logic [24:0] BG_SIZE_DEF = 25'h0008000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } dl_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  // Byte-lane strobes for a 16-bit word: upper lane when sel is set.
  function automatic logic [1:0] byte_strobes(input logic sel);
    return {sel, ~sel};
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// Capture FIFO for download bytes; head entry is presented through a register.
module dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_48M,
  input  logic        RESETn,
  input  logic        push,
  input  logic        pop,
  input  dl_entry_t   wr_data,
  output dl_entry_t   rd_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  dl_entry_t     mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage array, written only into a free slot
  always_ff @(posedge clk_48M) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and the registered head entry
  always_ff @(posedge clk_48M or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      rd_data  <= {$bits(dl_entry_t){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      rd_data <= mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/rom_dl_ctrl.sv
// Routes data_io download bytes to the CPU-ROM or background-ROM SDRAM port,
// one toggle-handshake write at a time.
module rom_dl_ctrl
  import rom_dl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] BG_BASE    = BG_BASE_DEF,
  parameter logic [24:0] BG_SIZE    = BG_SIZE_DEF
) (
  input  logic        clk_48M,
  input  logic        RESETn,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [13:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port_we,
  output logic        rom_loaded,
  output logic        overflow
);

  localparam int CW = $clog2(FIFO_DEPTH);

  dl_state_t   state_r;
  logic        sel2_r;
  logic        wr_d_r;
  logic        downl_d_r;
  logic        fall_seen_r;
  logic        capture_s;
  logic        downl_rise_s;
  logic        downl_fall_s;
  logic        pop_s;
  logic        full_s;
  logic        empty_s;
  logic [CW:0] count_s;
  dl_entry_t   head_s;
  dl_entry_t   push_data_s;
  logic [24:0] off_s;
  logic        to_p1_s;
  logic        to_p2_s;

  assign capture_s    = ioctl_downl & ioctl_wr & ~wr_d_r;
  assign downl_rise_s = ioctl_downl & ~downl_d_r;
  assign downl_fall_s = ~ioctl_downl & downl_d_r;
  assign push_data_s  = {ioctl_addr, ioctl_dout};
  assign pop_s        = (state_r == ST_ISSUE);

  // Background offset also decides the region: below base wraps to a huge value
  assign off_s   = head_s.addr - BG_BASE;
  assign to_p1_s = (head_s.addr < BG_BASE);
  assign to_p2_s = ~to_p1_s & (off_s < BG_SIZE);

  dl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_48M (clk_48M),
    .RESETn  (RESETn),
    .push    (capture_s),
    .pop     (pop_s),
    .wr_data (push_data_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

  // Request engine: issue the head entry, then hold until the port acknowledges
  always_ff @(posedge clk_48M or negedge RESETn) begin
    if (!RESETn) begin
      state_r   <= ST_IDLE;
      sel2_r    <= 1'b0;
      port1_req <= 1'b0;
      port1_a   <= 23'd0;
      port1_ds  <= 2'b00;
      port1_d   <= 16'h0000;
      port2_req <= 1'b0;
      port2_a   <= 14'd0;
      port2_ds  <= 2'b00;
      port2_d   <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (to_p1_s) begin
            port1_a   <= head_s.addr[23:1];
            port1_ds  <= byte_strobes(head_s.addr[0]);
            port1_d   <= {2{head_s.data}};
            port1_req <= ~port1_req;
            sel2_r    <= 1'b0;
            state_r   <= ST_WAIT_ACK;
          end else if (to_p2_s) begin
            port2_a   <= {off_s[12:0], off_s[14]};
            port2_ds  <= byte_strobes(off_s[13]);
            port2_d   <= {2{head_s.data}};
            port2_req <= ~port2_req;
            sel2_r    <= 1'b1;
            state_r   <= ST_WAIT_ACK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT_ACK: begin
          if (sel2_r ? (port2_ack == port2_req) : (port1_ack == port1_req)) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Edge detectors and sticky status flags; a new download clears the flags
  always_ff @(posedge clk_48M or negedge RESETn) begin
    if (!RESETn) begin
      wr_d_r      <= 1'b0;
      downl_d_r   <= 1'b0;
      port_we     <= 1'b0;
      fall_seen_r <= 1'b0;
      rom_loaded  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_d_r    <= ioctl_wr;
      downl_d_r <= ioctl_downl;
      port_we   <= ioctl_downl;
      if (downl_rise_s) begin
        fall_seen_r <= 1'b0;
        rom_loaded  <= 1'b0;
        overflow    <= 1'b0;
      end else begin
        if (downl_fall_s) begin
          fall_seen_r <= 1'b1;
        end
        if (fall_seen_r && (count_s == {(CW+1){1'b0}}) && (state_r == ST_IDLE)) begin
          rom_loaded <= 1'b1;
        end
        if (capture_s && full_s) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl with a transaction-level routing/queue model
// and an SDRAM responder that echoes acks after a programmable delay.
module tb_rom_dl_ctrl;

  localparam int          DEPTH = 4;
  localparam logic [24:0] BGB   = 25'h000E000;
  localparam logic [24:0] BGS   = 25'h0008000;

  logic        clk_48M = 1'b0;
  logic        RESETn;
  logic        ioctl_downl;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req;
  logic        port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req;
  logic        port2_ack;
  logic [13:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        port_we;
  logic        rom_loaded;
  logic        overflow;

  typedef struct {
    int          port;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } req_t;

  req_t fifo_m[$];
  req_t exp_q[$];
  req_t held;
  bit   busy_m  = 1'b0;
  bit   exp_ovf = 1'b0;
  bit   exp_we  = 1'b0;
  int   ack_dly = 3;
  int   tog1    = 0;
  int   tog2    = 0;
  int   checks  = 0;
  int   errors  = 0;

  always #10 clk_48M = ~clk_48M;

  rom_dl_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .BG_BASE    (BGB),
    .BG_SIZE    (BGS)
  ) dut (
    .clk_48M     (clk_48M),
    .RESETn      (RESETn),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .port1_req   (port1_req),
    .port1_ack   (port1_ack),
    .port1_a     (port1_a),
    .port1_ds    (port1_ds),
    .port1_d     (port1_d),
    .port2_req   (port2_req),
    .port2_ack   (port2_ack),
    .port2_a     (port2_a),
    .port2_ds    (port2_ds),
    .port2_d     (port2_d),
    .port_we     (port_we),
    .rom_loaded  (rom_loaded),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Where a byte must land, straight from the address map
  function automatic req_t route(input logic [24:0] addr, input logic [7:0] data);
    req_t        r;
    logic [24:0] off;
    r.d = {data, data};
    if (addr < BGB) begin
      r.port = 1;
      r.a    = addr[23:1];
      r.ds   = {addr[0], ~addr[0]};
    end else if (addr < BGB + BGS) begin
      off    = addr - BGB;
      r.port = 2;
      r.a    = {9'd0, off[12:0], off[14]};
      r.ds   = {off[13], ~off[13]};
    end else begin
      r.port = 0;
      r.a    = 23'd0;
      r.ds   = 2'b00;
    end
    return r;
  endfunction

  function automatic void model_advance();
    req_t r;
    while (!busy_m && fifo_m.size() > 0) begin
      r = fifo_m.pop_front();
      if (r.port != 0) begin
        busy_m = 1'b1;
        exp_q.push_back(r);
      end
    end
  endfunction

  function automatic void model_capture(input logic [24:0] addr, input logic [7:0] data);
    if (fifo_m.size() >= DEPTH) begin
      exp_ovf = 1'b1;
    end else begin
      fifo_m.push_back(route(addr, data));
      model_advance();
    end
  endfunction

  task automatic set_downl(input logic v);
    logic was;
    was         = ioctl_downl;
    ioctl_downl = v;
    @(posedge clk_48M);
    exp_we = v;
    if (v && !was) exp_ovf = 1'b0;
    #1;
  endtask

  task automatic write_byte(input logic [24:0] addr, input logic [7:0] data, input int hold);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(posedge clk_48M);
    if (ioctl_downl) model_capture(addr, data);
    repeat (hold - 1) @(posedge clk_48M);
    #1;
    ioctl_wr = 1'b0;
    repeat (3) @(posedge clk_48M);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_m.size() != 0 || busy_m ||
            port1_req != port1_ack || port2_req != port2_ack) && n < budget) begin
      @(posedge clk_48M);
      n++;
    end
    chk("drain_timeout", 64'(n < budget), 64'd1);
    repeat (4) @(posedge clk_48M);
    #1;
  endtask

  // SDRAM side: echo req onto ack after ack_dly cycles
  initial begin : responder
    int cnt;
    cnt       = 0;
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    forever begin
      @(posedge clk_48M);
      #1;
      if (!RESETn) begin
        cnt       = 0;
        port1_ack = 1'b0;
        port2_ack = 1'b0;
      end else if (port1_req != port1_ack || port2_req != port2_ack) begin
        cnt++;
        if (cnt >= ack_dly) begin
          port1_ack = port1_req;
          port2_ack = port2_req;
          cnt       = 0;
          busy_m    = 1'b0;
          model_advance();
        end
      end
    end
  end

  initial begin : compare
    logic p1_prev, p2_prev, a1_prev, a2_prev;
    bit   t1, t2;
    p1_prev = 1'b0; p2_prev = 1'b0; a1_prev = 1'b0; a2_prev = 1'b0;
    held.port = 0; held.a = 23'd0; held.ds = 2'b00; held.d = 16'h0000;
    forever begin
      @(negedge clk_48M);
      if (RESETn) begin
        chk("port_we", 64'(port_we), 64'(exp_we));
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        t1 = (port1_req != p1_prev);
        t2 = (port2_req != p2_prev);
        if (t1) tog1++;
        if (t2) tog2++;
        if (t1 || t2) begin
          chk("one_outstanding",
              64'((p1_prev != a1_prev) || (p2_prev != a2_prev) || (t1 && t2)), 64'd0);
          chk("req_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            held = exp_q.pop_front();
            chk("req_port", t2 ? 64'd2 : 64'd1, 64'(held.port));
            if (held.port == 1) begin
              chk("p1_a", 64'(port1_a), 64'(held.a));
              chk("p1_ds", 64'(port1_ds), 64'(held.ds));
              chk("p1_d", 64'(port1_d), 64'(held.d));
            end else begin
              chk("p2_a", 64'(port2_a), 64'(held.a));
              chk("p2_ds", 64'(port2_ds), 64'(held.ds));
              chk("p2_d", 64'(port2_d), 64'(held.d));
            end
          end
        end else begin
          if (port1_req != port1_ack && held.port == 1)
            chk("p1_stable", {23'd0, port1_a, port1_ds, port1_d},
                {23'd0, held.a, held.ds, held.d});
          if (port2_req != port2_ack && held.port == 2)
            chk("p2_stable", {32'd0, port2_a, port2_ds, port2_d},
                {32'd0, held.a[13:0], held.ds, held.d});
        end
      end
      p1_prev = port1_req;
      p2_prev = port2_req;
      a1_prev = port1_ack;
      a2_prev = port2_ack;
    end
  end

  initial begin : main
    int n;
    int base;
    RESETn      = 1'b0;
    ioctl_downl = 1'b0;
    ioctl_wr    = 1'b0;
    ioctl_addr  = 25'd0;
    ioctl_dout  = 8'd0;
    repeat (3) @(posedge clk_48M);
    @(negedge clk_48M);
    chk("rst_req", 64'({port1_req, port2_req}), 64'd0);
    chk("rst_p1", {23'd0, port1_a, port1_ds, port1_d}, 64'd0);
    chk("rst_p2", {32'd0, port2_a, port2_ds, port2_d}, 64'd0);
    chk("rst_flags", 64'({port_we, rom_loaded, overflow}), 64'd0);
    RESETn = 1'b1;
    @(posedge clk_48M);
    #1;

    // CPU ROM byte, odd address
    set_downl(1'b1);
    ack_dly = 5;
    write_byte(25'h0000003, 8'hA5, 1);
    n = 0;
    while (port1_req !== 1'b1 && n < 10) begin @(negedge clk_48M); n++; end
    chk("p1_req_toggled", 64'(port1_req), 64'd1);
    chk("lit_p1_a", 64'(port1_a), 64'h000001);
    chk("lit_p1_ds", 64'(port1_ds), 64'd2);
    chk("lit_p1_d", 64'(port1_d), 64'hA5A5);
    wait_drain(100);
    chk("lit_tog1_a", 64'(tog1), 64'd1);

    // Background ROM byte, offset 0x2005
    write_byte(BGB + 25'h0002005, 8'h3C, 1);
    n = 0;
    while (port2_req !== 1'b1 && n < 10) begin @(negedge clk_48M); n++; end
    chk("p2_req_toggled", 64'(port2_req), 64'd1);
    chk("lit_p2_a", 64'(port2_a), 64'h000A);
    chk("lit_p2_ds", 64'(port2_ds), 64'd2);
    chk("lit_p2_d", 64'(port2_d), 64'h3C3C);
    wait_drain(100);
    chk("lit_tog2_b", 64'(tog2), 64'd1);

    // First address past the background region is discarded
    write_byte(25'h0016000, 8'h77, 1);
    repeat (10) @(posedge clk_48M);
    #1;
    wait_drain(100);
    chk("lit_discard_tog", 64'({tog1[7:0], tog2[7:0]}), 64'h0101);

    // Long write strobe captures once
    write_byte(25'h0000010, 8'h11, 10);
    wait_drain(100);
    chk("lit_long_wr_tog1", 64'(tog1), 64'd2);

    // Ack held off: one in flight, four queued, sixth byte lost
    ack_dly = 40;
    for (int i = 0; i < 6; i++) write_byte(25'h0000100 + 25'(i), 8'h40 + 8'(i), 1);
    chk("lit_overflow_set", 64'(overflow), 64'd1);
    wait_drain(600);
    chk("lit_overflow_tog1", 64'(tog1), 64'd7);

    // End of download, then a new one clears the sticky flags
    set_downl(1'b0);
    wait_drain(100);
    chk("lit_loaded_idle", 64'(rom_loaded), 64'd1);
    set_downl(1'b1);
    @(negedge clk_48M);
    chk("lit_flags_cleared", 64'({rom_loaded, overflow}), 64'd0);
    @(posedge clk_48M);
    #1;

    // Download ends with three entries still queued
    ack_dly = 20;
    base    = tog1;
    for (int i = 0; i < 4; i++) write_byte(25'h0000200 + 25'(2 * i), 8'h90 + 8'(i), 1);
    set_downl(1'b0);
    n = 0;
    forever begin
      @(negedge clk_48M);
      if ((tog1 == base + 4 && port1_ack == port1_req) || n >= 400) break;
      chk("loaded_while_draining", 64'(rom_loaded), 64'd0);
      n++;
    end
    chk("drain3_timeout", 64'(n < 400), 64'd1);
    chk("loaded_at_last_ack", 64'(rom_loaded), 64'd0);
    @(negedge clk_48M);
    chk("loaded_fsm_idle", 64'(rom_loaded), 64'd0);
    @(negedge clk_48M);
    chk("loaded_set", 64'(rom_loaded), 64'd1);
    @(posedge clk_48M);
    #1;
    wait_drain(100);
    chk("final_queue_empty", 64'(exp_q.size() + fifo_m.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
